// File: rtl/index_write_arbiter.sv
// Write-port owner for the monitor_index frame memory: round-robin between the
// character (CH) and trajectory (TR) renderers, plus a full-frame clear engine.
module index_write_arbiter #(
    parameter int         NUM_PIXELS = 307200,
    parameter logic [2:0] BG_INDEX   = 3'd0,
    parameter int         ADDR_W     = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_start,
    input  logic              ch_req,
    input  logic [ADDR_W-1:0] ch_addr,
    input  logic [2:0]        ch_data,
    output logic              ch_ack,
    input  logic              tr_req,
    input  logic [ADDR_W-1:0] tr_addr,
    input  logic [2:0]        tr_data,
    output logic              tr_ack,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [2:0]        mem_wdata,
    output logic              mem_wenable,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              oob_err
);

    localparam logic [ADDR_W:0]   NUM_PIX_W = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clrCnt;
    logic              r_rrPtr;
    logic              r_chAck;
    logic              r_trAck;
    logic [ADDR_W-1:0] r_waddr;
    logic [2:0]        r_wdata;
    logic              r_wen;
    logic              r_clearBusy;
    logic              r_clearDone;
    logic              r_oobErr;

    logic              w_chElig;
    logic              w_trElig;
    logic              w_grantCh;
    logic              w_grantTr;
    logic [ADDR_W-1:0] w_gAddr;
    logic [2:0]        w_gData;
    logic              w_gOob;

    // A requester still held during its ack cycle is not eligible; r_rrPtr=1 prefers TR.
    always_comb begin
        w_chElig  = ch_req & ~r_chAck;
        w_trElig  = tr_req & ~r_trAck;
        w_grantTr = w_trElig & (~w_chElig | r_rrPtr);
        w_grantCh = w_chElig & ~w_grantTr;
        w_gAddr   = w_grantTr ? tr_addr : ch_addr;
        w_gData   = w_grantTr ? tr_data : ch_data;
        w_gOob    = ({1'b0, w_gAddr} >= NUM_PIX_W);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_clrCnt    <= '0;
            r_rrPtr     <= 1'b0;
            r_chAck     <= 1'b0;
            r_trAck     <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_clearBusy <= 1'b0;
            r_clearDone <= 1'b0;
            r_oobErr    <= 1'b0;
        end else begin
            r_chAck     <= 1'b0;
            r_trAck     <= 1'b0;
            r_wen       <= 1'b0;
            r_clearDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The first IDLE cycle after a sweep still sees busy high: that is the done pulse.
                    r_clearBusy <= 1'b0;
                    r_clearDone <= r_clearBusy;
                    if (clear_start) begin
                        r_state     <= CLEAR;
                        r_clearBusy <= 1'b1;
                        r_waddr     <= '0;
                        r_wdata     <= BG_INDEX;
                        r_wen       <= 1'b1;
                        r_clrCnt    <= ADDR_W'(1);
                    end else if (w_grantCh | w_grantTr) begin
                        r_waddr  <= w_gAddr;
                        r_wdata  <= w_gData;
                        r_wen    <= ~w_gOob;
                        r_oobErr <= r_oobErr | w_gOob;
                        r_chAck  <= w_grantCh;
                        r_trAck  <= w_grantTr;
                        r_rrPtr  <= w_grantCh;
                    end
                end
                CLEAR: begin
                    r_clearBusy <= 1'b1;
                    r_waddr     <= r_clrCnt;
                    r_wdata     <= BG_INDEX;
                    r_wen       <= 1'b1;
                    if (r_clrCnt == LAST_ADDR) begin
                        r_state  <= IDLE;
                        r_clrCnt <= '0;
                    end else begin
                        r_clrCnt <= r_clrCnt + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ch_ack      = r_chAck;
    assign tr_ack      = r_trAck;
    assign mem_waddr   = r_waddr;
    assign mem_wdata   = r_wdata;
    assign mem_wenable = r_wen;
    assign clear_busy  = r_clearBusy;
    assign clear_done  = r_clearDone;
    assign oob_err     = r_oobErr;

endmodule
